// File: rtl/signal_event_unit.sv
// Edge detect, change detect and clock-enabled delay line sharing clk/rst/ce.
// Define SIGEVT_DLY_RST_EN to give the delay stages an asynchronous reset.
module signal_event_unit #(
  parameter int CHG_WID = 16,
  parameter int DLY_WID = 5,
  parameter int DLY_DEP = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               ed_i,
  output logic               pe,
  output logic               ne,
  output logic               ee,
  input  logic [CHG_WID-1:0] cd_i,
  output logic               cd,
  input  logic [DLY_WID-1:0] dly_i,
  output logic [DLY_WID-1:0] dly_o
);

  logic               ed_q;
  logic [CHG_WID-1:0] cd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ed_q <= 1'b0;
      cd_q <= '0;
    end else if (ce) begin
      ed_q <= ed_i;
      cd_q <= cd_i;
    end
  end

  assign pe = ed_i & ~ed_q;
  assign ne = ~ed_i & ed_q;
  assign ee = ed_i ^ ed_q;
  assign cd = (cd_i != cd_q);

  generate
    if (DLY_DEP == 0) begin : g_wire
      assign dly_o = dly_i;
    end else begin : g_line
      logic [DLY_WID-1:0] stg [DLY_DEP];

`ifdef SIGEVT_DLY_RST_EN
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < DLY_DEP; k++)
            stg[k] <= '0;
        end else if (ce) begin
          stg[0] <= dly_i;
          for (int k = 1; k < DLY_DEP; k++)
            stg[k] <= stg[k-1];
        end
      end
`else
      // No reset so the stages can map onto shift-register primitives.
      always_ff @(posedge clk) begin
        if (ce) begin
          stg[0] <= dly_i;
          for (int k = 1; k < DLY_DEP; k++)
            stg[k] <= stg[k-1];
        end
      end
`endif

      assign dly_o = stg[DLY_DEP-1];
    end
  endgenerate

endmodule

// File: tb/tb_signal_event_unit.sv
// Directed plus random stimulus against a queue-based reference model.
module tb_signal_event_unit;

  localparam int DEP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        ed_i;
  logic [15:0] cd_i;
  logic [4:0]  dly_i;
  logic        pe, ne, ee, cd;
  logic [4:0]  dly_o;
  logic        pe0, ne0, ee0, cd0;
  logic [4:0]  dly_o0;

  int checks = 0;
  int failures = 0;

  logic        m_ed;
  logic [15:0] m_cd;
  logic [4:0]  hist[$];

  always #5 clk = ~clk;

  signal_event_unit #(.CHG_WID(16), .DLY_WID(5), .DLY_DEP(DEP)) u_dut (
    .clk(clk), .rst(rst), .ce(ce),
    .ed_i(ed_i), .pe(pe), .ne(ne), .ee(ee),
    .cd_i(cd_i), .cd(cd),
    .dly_i(dly_i), .dly_o(dly_o)
  );

  signal_event_unit #(.CHG_WID(16), .DLY_WID(5), .DLY_DEP(0)) u_dut0 (
    .clk(clk), .rst(rst), .ce(ce),
    .ed_i(ed_i), .pe(pe0), .ne(ne0), .ee(ee0),
    .cd_i(cd_i), .cd(cd0),
    .dly_i(dly_i), .dly_o(dly_o0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check mid-low phase, advance model on posedge.
  task automatic step(input logic e, input logic [15:0] c,
                      input logic [4:0] d, input logic en, input logic r);
    ed_i = e; cd_i = c; dly_i = d; ce = en; rst = r;
    if (r) begin
      m_ed = 1'b0;
      m_cd = '0;
      hist.delete();
`ifdef SIGEVT_DLY_RST_EN
      repeat (DEP) hist.push_back(5'd0);
`endif
    end
    #1;
    chk("pe", pe, e & ~m_ed);
    chk("ne", ne, ~e & m_ed);
    chk("ee", ee, e ^ m_ed);
    chk("pe_ne_excl", pe & ne, 1'b0);
    chk("cd", cd, c != m_cd);
    if (hist.size() >= DEP)
      chk("dly_o", dly_o, hist[hist.size()-DEP]);
    chk("dly_o_dep0", dly_o0, d);
    chk("pe_dep0", pe0, e & ~m_ed);
    @(posedge clk);
    if (!r && en) begin
      m_ed = e;
      m_cd = c;
      hist.push_back(d);
      if (hist.size() > DEP) void'(hist.pop_front());
    end
    @(negedge clk);
  endtask

  logic [15:0] rc;

  initial begin
    m_ed = 1'b0;
    m_cd = '0;
    rst = 1'b1; ce = 1'b0; ed_i = 1'b0; cd_i = '0; dly_i = '0;
    @(negedge clk);
    step(1'b0, 16'h0000, 5'd0, 1'b1, 1'b1);
    step(1'b1, 16'h0003, 5'd0, 1'b1, 1'b1);
    // edge detection: rise, hold, fall
    step(1'b0, 16'h0000, 5'd0, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 5'd0, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 5'd0, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 5'd0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 5'd0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 5'd0, 1'b1, 1'b0);
    // clock enable holds pe
    step(1'b1, 16'h0000, 5'd0, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 5'd0, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 5'd0, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 5'd0, 1'b1, 1'b0);
    // change detection
    step(1'b1, 16'h0001, 5'd0, 1'b1, 1'b0);
    step(1'b1, 16'h0001, 5'd0, 1'b1, 1'b0);
    step(1'b1, 16'h0001, 5'd0, 1'b1, 1'b0);
    step(1'b1, 16'h8001, 5'd0, 1'b1, 1'b0);
    step(1'b1, 16'h8001, 5'd0, 1'b1, 1'b0);
    // delay line with a stalled cycle
    for (int i = 1; i <= 10; i++)
      step(1'b1, 16'h8001, 5'(i), (i != 6), 1'b0);
    // mid-stream reset with ed_q=1, ed_i=0
    step(1'b0, 16'h0005, 5'd11, 1'b1, 1'b1);
    step(1'b0, 16'h0005, 5'h15, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 16'h0005, 5'(20 + i), 1'b1, 1'b0);
    // random
    rc = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) rc = 16'($urandom);
      step(1'($urandom), rc, 5'($urandom), ($urandom_range(3) != 0),
           ($urandom_range(39) == 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
